// File: rtl/uart_rx_keypad.sv
// 8N1 serial receiver for the keypad link: recovers bytes and decodes the
// ASCII symbols '0'-'9' and 'u' back into the 4-bit switch code on the LEDs.
module uart_rx_keypad #(
   parameter int CLKS_PER_BIT = 5702
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic [3:0] leds,
   output logic       char_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             data_valid_q, data_valid_d;
   logic             frame_err_q, frame_err_d;
   logic [3:0]       leds_q, leds_d;
   logic             char_err_q, char_err_d;
   logic             rx_meta_q, rx_s_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      data_d       = data_q;
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            bit_idx_d = 3'd0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            // Mid-start-bit check rejects glitches shorter than half a bit
            if (cnt_q == HALF_CNT) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               state_d   = rx_s_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rx_s_q;
               if (bit_idx_q == 3'd7) state_d = STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d       = shift_q;
                  data_valid_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_HIGH: begin
            // A held-low line (break) must end before another start is accepted
            cnt_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      leds_d     = leds_q;
      char_err_d = 1'b0;
      if (data_valid_q) begin
         if (data_q >= 8'h30 && data_q <= 8'h39) leds_d = data_q[3:0];
         else if (data_q == 8'h75)               leds_d = 4'b1111;
         else                                    char_err_d = 1'b1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'h00;
         data_q       <= 8'h00;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         leds_q       <= 4'b0000;
         char_err_q   <= 1'b0;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         leds_q       <= leds_d;
         char_err_q   <= char_err_d;
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
      end
   end

   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign leds       = leds_q;
   assign char_err   = char_err_q;

endmodule

// File: tb/tb_uart_rx_keypad.sv
// Directed bench for uart_rx_keypad at 16 clocks per bit: good frames,
// back-to-back frames, bad symbols, framing errors, glitches and reset abort.
module tb_uart_rx_keypad;

   localparam int CPB = 16;

   logic       sysclk = 1'b0;
   logic       rst_n  = 1'b1;
   logic       rx     = 1'b1;
   logic [7:0] data;
   logic       data_valid, frame_err, char_err;
   logic [3:0] leds;

   int check_cnt = 0;
   int pass_cnt  = 0;

   int dv_cnt = 0, fe_cnt = 0, ce_cnt = 0, wide_cnt = 0, both_cnt = 0;
   logic prev_dv = 1'b0, prev_fe = 1'b0, prev_ce = 1'b0;
   logic [3:0] last_leds = 4'b0000;
   logic [3:0] leds_log[$];

   uart_rx_keypad #(.CLKS_PER_BIT(CPB)) dut (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .rx        (rx),
      .data      (data),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .leds      (leds),
      .char_err  (char_err)
   );

   always #5 sysclk = ~sysclk;

   // Strobe and LED activity monitor, sampled on the inactive edge
   always @(negedge sysclk) begin
      if (data_valid === 1'b1) dv_cnt = dv_cnt + 1;
      if (frame_err === 1'b1)  fe_cnt = fe_cnt + 1;
      if (char_err === 1'b1)   ce_cnt = ce_cnt + 1;
      if ((data_valid === 1'b1 && prev_dv) || (frame_err === 1'b1 && prev_fe) ||
          (char_err === 1'b1 && prev_ce))
         wide_cnt = wide_cnt + 1;
      if (data_valid === 1'b1 && frame_err === 1'b1) both_cnt = both_cnt + 1;
      prev_dv = (data_valid === 1'b1);
      prev_fe = (frame_err === 1'b1);
      prev_ce = (char_err === 1'b1);
      if (leds !== last_leds && !$isunknown(leds)) begin
         leds_log.push_back(leds);
         last_leds = leds;
      end
   end

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge sysclk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_bit);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge sysclk);
   endtask

   task automatic test_reset;
      @(negedge sysclk);
      rst_n = 1'b0;
      repeat (3) @(negedge sysclk);
      check_cnt++; if (data !== 8'h00) $display("FAIL reset_data got=%h exp=00", data); else pass_cnt++;
      check_cnt++; if (leds !== 4'b0000) $display("FAIL reset_leds got=%b exp=0000", leds); else pass_cnt++;
      check_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_dv got=%b exp=0", data_valid); else pass_cnt++;
      check_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_fe got=%b exp=0", frame_err); else pass_cnt++;
      check_cnt++; if (char_err !== 1'b0) $display("FAIL reset_ce got=%b exp=0", char_err); else pass_cnt++;
      rst_n = 1'b1;
      idle(4);
   endtask

   task automatic test_single;
      int dv0, ce0, fe0;
      dv0 = dv_cnt; ce0 = ce_cnt; fe0 = fe_cnt;
      send_byte(8'h35, 1'b1);
      idle(4);
      check_cnt++; if (data !== 8'h35) $display("FAIL t1_data got=%h exp=35", data); else pass_cnt++;
      check_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL t1_dv_pulses got=%0d exp=1", dv_cnt - dv0); else pass_cnt++;
      check_cnt++; if (leds !== 4'b0101) $display("FAIL t1_leds got=%b exp=0101", leds); else pass_cnt++;
      check_cnt++; if (ce_cnt - ce0 !== 0) $display("FAIL t1_char_err got=%0d exp=0", ce_cnt - ce0); else pass_cnt++;
      check_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL t1_frame_err got=%0d exp=0", fe_cnt - fe0); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int dv0, n0;
      dv0 = dv_cnt; n0 = leds_log.size();
      send_byte(8'h75, 1'b1);
      send_byte(8'h39, 1'b1);
      idle(4);
      check_cnt++; if (dv_cnt - dv0 !== 2) $display("FAIL t2_dv_pulses got=%0d exp=2", dv_cnt - dv0); else pass_cnt++;
      check_cnt++; if (data !== 8'h39) $display("FAIL t2_data got=%h exp=39", data); else pass_cnt++;
      check_cnt++;
      if (leds_log.size() != n0 + 2) $display("FAIL t2_leds_changes got=%0d exp=2", leds_log.size() - n0);
      else pass_cnt++;
      check_cnt++;
      if (leds_log.size() < n0 + 2 || leds_log[n0] !== 4'b1111 || leds_log[n0+1] !== 4'b1001)
         $display("FAIL t2_leds_seq got=%b exp=1111,1001", leds);
      else pass_cnt++;
   endtask

   task automatic test_bad_char;
      int dv0, ce0;
      send_byte(8'h33, 1'b1);
      idle(4);
      check_cnt++; if (leds !== 4'b0011) $display("FAIL t3_leds_3 got=%b exp=0011", leds); else pass_cnt++;
      dv0 = dv_cnt; ce0 = ce_cnt;
      send_byte(8'h41, 1'b1);
      idle(4);
      check_cnt++; if (data !== 8'h41) $display("FAIL t3_data got=%h exp=41", data); else pass_cnt++;
      check_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL t3_dv_pulses got=%0d exp=1", dv_cnt - dv0); else pass_cnt++;
      check_cnt++; if (ce_cnt - ce0 !== 1) $display("FAIL t3_char_err got=%0d exp=1", ce_cnt - ce0); else pass_cnt++;
      check_cnt++; if (leds !== 4'b0011) $display("FAIL t3_leds_kept got=%b exp=0011", leds); else pass_cnt++;
   endtask

   task automatic test_frame_err;
      int dv0, fe0;
      dv0 = dv_cnt; fe0 = fe_cnt;
      send_byte(8'h32, 1'b0);
      rx = 1'b0;
      repeat (40) @(negedge sysclk);
      check_cnt++; if (data !== 8'h41) $display("FAIL t4_break_data got=%h exp=41", data); else pass_cnt++;
      check_cnt++; if (leds !== 4'b0011) $display("FAIL t4_break_leds got=%b exp=0011", leds); else pass_cnt++;
      check_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL t4_fe_pulses got=%0d exp=1", fe_cnt - fe0); else pass_cnt++;
      check_cnt++; if (dv_cnt - dv0 !== 0) $display("FAIL t4_dv_in_break got=%0d exp=0", dv_cnt - dv0); else pass_cnt++;
      idle(8);
      send_byte(8'h37, 1'b1);
      idle(4);
      check_cnt++; if (data !== 8'h37) $display("FAIL t4_data got=%h exp=37", data); else pass_cnt++;
      check_cnt++; if (leds !== 4'b0111) $display("FAIL t4_leds got=%b exp=0111", leds); else pass_cnt++;
      check_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL t4_fe_total got=%0d exp=1", fe_cnt - fe0); else pass_cnt++;
   endtask

   task automatic test_glitch;
      int dv0, fe0, ce0;
      dv0 = dv_cnt; fe0 = fe_cnt; ce0 = ce_cnt;
      rx = 1'b0;
      repeat (5) @(negedge sysclk);
      idle(30);
      check_cnt++;
      if (dv_cnt - dv0 + fe_cnt - fe0 + ce_cnt - ce0 !== 0)
         $display("FAIL t5_glitch_strobes got=%0d exp=0", dv_cnt - dv0 + fe_cnt - fe0 + ce_cnt - ce0);
      else pass_cnt++;
      check_cnt++; if (data !== 8'h37) $display("FAIL t5_glitch_data got=%h exp=37", data); else pass_cnt++;
      send_byte(8'h31, 1'b1);
      idle(4);
      check_cnt++; if (data !== 8'h31) $display("FAIL t5_data got=%h exp=31", data); else pass_cnt++;
      check_cnt++; if (leds !== 4'b0001) $display("FAIL t5_leds got=%b exp=0001", leds); else pass_cnt++;
      check_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL t5_dv_pulses got=%0d exp=1", dv_cnt - dv0); else pass_cnt++;
   endtask

   task automatic test_reset_abort;
      logic [7:0] b;
      int dv0, ce0, fe0;
      b = 8'h38;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      rx = b[4];
      repeat (CPB / 2) @(negedge sysclk);
      rst_n = 1'b0;
      repeat (2) @(negedge sysclk);
      check_cnt++; if (data !== 8'h00) $display("FAIL t6_rst_data got=%h exp=00", data); else pass_cnt++;
      check_cnt++; if (leds !== 4'b0000) $display("FAIL t6_rst_leds got=%b exp=0000", leds); else pass_cnt++;
      rst_n = 1'b1;
      dv0 = dv_cnt; ce0 = ce_cnt; fe0 = fe_cnt;
      idle(20);
      check_cnt++;
      if (dv_cnt - dv0 + fe_cnt - fe0 !== 0)
         $display("FAIL t6_aborted_strobes got=%0d exp=0", dv_cnt - dv0 + fe_cnt - fe0);
      else pass_cnt++;
      send_byte(8'h32, 1'b1);
      idle(4);
      check_cnt++; if (data !== 8'h32) $display("FAIL t6_data got=%h exp=32", data); else pass_cnt++;
      check_cnt++; if (leds !== 4'b0010) $display("FAIL t6_leds got=%b exp=0010", leds); else pass_cnt++;
      check_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL t6_dv_pulses got=%0d exp=1", dv_cnt - dv0); else pass_cnt++;
      check_cnt++; if (ce_cnt - ce0 !== 0) $display("FAIL t6_char_err got=%0d exp=0", ce_cnt - ce0); else pass_cnt++;
   endtask

   task automatic test_strobe_shape;
      check_cnt++; if (wide_cnt !== 0) $display("FAIL strobe_width got=%0d exp=0", wide_cnt); else pass_cnt++;
      check_cnt++; if (both_cnt !== 0) $display("FAIL dv_fe_exclusive got=%0d exp=0", both_cnt); else pass_cnt++;
   endtask

   initial begin
      idle(3);
      test_reset();
      test_single();
      test_back_to_back();
      test_bad_char();
      test_frame_err();
      test_glitch();
      test_reset_abort();
      test_strobe_shape();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
